// File: rtl/sigmul_rr_scheduler.sv
// sigmul_rr_scheduler
// Shares one combinational significand multiplier between two FMA lanes.
// The winning lane's operands are registered onto mul_a/mul_b, and the lane id
// and tag travel down a fixed-latency pipeline beside the sum/carry result.
// Each lane gets its result back through a credit-protected FWFT FIFO.
// Optional build macro SIGMUL_SCHED_STATS_EN adds saturating issue/stall counters.

module sigmul_rr_scheduler #(
    parameter int SIG_WIDTH = 23,
    parameter int LATENCY   = 2,
    parameter int TAG_W     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [SIG_WIDTH:0]     req0_a,
    input  logic [SIG_WIDTH:0]     req0_b,
    input  logic [TAG_W-1:0]       req0_tag,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [SIG_WIDTH:0]     req1_a,
    input  logic [SIG_WIDTH:0]     req1_b,
    input  logic [TAG_W-1:0]       req1_tag,
    output logic [SIG_WIDTH:0]     mul_a,
    output logic [SIG_WIDTH:0]     mul_b,
    input  logic [2*SIG_WIDTH+3:0] mul_sum,
    input  logic [2*SIG_WIDTH+3:0] mul_carry,
    output logic                   rsp0_valid,
    input  logic                   rsp0_ready,
    output logic [2*SIG_WIDTH+3:0] rsp0_sum,
    output logic [2*SIG_WIDTH+3:0] rsp0_carry,
    output logic [TAG_W-1:0]       rsp0_tag,
    output logic                   rsp1_valid,
    input  logic                   rsp1_ready,
    output logic [2*SIG_WIDTH+3:0] rsp1_sum,
    output logic [2*SIG_WIDTH+3:0] rsp1_carry,
    output logic [TAG_W-1:0]       rsp1_tag
`ifdef SIGMUL_SCHED_STATS_EN
    ,
    output logic [15:0]            stat_issue0,
    output logic [15:0]            stat_issue1,
    output logic [15:0]            stat_stall
`endif
);

    localparam int RES_W = 2*SIG_WIDTH+4;
    localparam int DEPTH = LATENCY+1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [1:0]       req_valid, rsp_ready, elig, grant, push, pop, rsp_avail;
    logic [CNT_W-1:0] credit [2];
    logic             last_grant, accept, win;

    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};

    // Eligibility and round-robin grant; a lane out of credit never wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        elig  = '0;
        grant = '0;
        if (!rst) begin
            for (int n = 0; n < 2; n++) elig[n] = req_valid[n] && (credit[n] != '0);
        end
        grant[0] = elig[0] && (!elig[1] || last_grant);
        grant[1] = elig[1] && (!elig[0] || !last_grant);
    end

    assign accept     = |grant;
    assign win        = grant[1];
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    // Operand register and round-robin pointer; both move only on an accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a      <= '0;
            mul_b      <= '0;
            last_grant <= 1'b1;
        end else if (accept) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            mul_a      <= win ? req1_a : req0_a;
            mul_b      <= win ? req1_b : req0_b;
            last_grant <= win;
        end
    end

    logic             c_valid [LATENCY];
    logic             c_id    [LATENCY];
    logic [TAG_W-1:0] c_tag   [LATENCY];

    // Control pipeline: valid, lane id and tag ride alongside the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < LATENCY; k++) begin
                c_valid[k] <= 1'b0;
                c_id[k]    <= 1'b0;
                c_tag[k]   <= '0;
            end
        end else begin
            c_valid[0] <= accept;
            c_id[0]    <= win;
            c_tag[0]   <= win ? req1_tag : req0_tag;
            for (int k = 1; k < LATENCY; k++) begin
                c_valid[k] <= c_valid[k-1];
                c_id[k]    <= c_id[k-1];
                c_tag[k]   <= c_tag[k-1];
            end
        end
    end

    logic [RES_W-1:0] wr_sum, wr_carry;

    generate
        if (LATENCY == 1) begin : g_direct
            assign wr_sum   = mul_sum;
            assign wr_carry = mul_carry;
        end else begin : g_stages
            logic [RES_W-1:0] d_sum   [LATENCY-1];
            logic [RES_W-1:0] d_carry [LATENCY-1];

            // Result stages: sample the multiplier one edge after issue, then shift.
            // NOTE: datapath and storage registers carry no reset; the control valids qualify them.
            always_ff @(posedge clk) begin
                d_sum[0]   <= mul_sum;
                d_carry[0] <= mul_carry;
                for (int k = 1; k < LATENCY-1; k++) begin
                    d_sum[k]   <= d_sum[k-1];
                    d_carry[k] <= d_carry[k-1];
                end
            end

            assign wr_sum   = d_sum[LATENCY-2];
            assign wr_carry = d_carry[LATENCY-2];
        end
    endgenerate

    assign push = {c_valid[LATENCY-1] & c_id[LATENCY-1], c_valid[LATENCY-1] & ~c_id[LATENCY-1]};
    assign pop  = rsp_avail & rsp_ready;

    logic [RES_W-1:0] f_sum   [2][DEPTH];
    logic [RES_W-1:0] f_carry [2][DEPTH];
    logic [TAG_W-1:0] f_tag   [2][DEPTH];
    logic [PTR_W-1:0] rd_ptr  [2];
    logic [PTR_W-1:0] wr_ptr  [2];
    logic [CNT_W-1:0] count   [2];

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    // FIFO storage writes.
    always_ff @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (push[n]) begin
                f_sum[n][wr_ptr[n]]   <= wr_sum;
                f_carry[n][wr_ptr[n]] <= wr_carry;
                f_tag[n][wr_ptr[n]]   <= c_tag[LATENCY-1];
            end
        end
    end

    // FIFO pointers, occupancy and per-lane credits (issue takes one, pop returns one).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < 2; n++) begin
                rd_ptr[n] <= '0;
                wr_ptr[n] <= '0;
                count[n]  <= '0;
                credit[n] <= CNT_W'(DEPTH);
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                assert (!(push[n] && count[n] == CNT_W'(DEPTH)));
                if (push[n]) wr_ptr[n] <= ptr_next(wr_ptr[n]);
                if (pop[n])  rd_ptr[n] <= ptr_next(rd_ptr[n]);
                count[n]  <= count[n] + CNT_W'(push[n]) - CNT_W'(pop[n]);
                credit[n] <= credit[n] + CNT_W'(pop[n]) - CNT_W'(grant[n]);
            end
        end
    end

    assign rsp_avail  = {count[1] != '0, count[0] != '0};
    assign rsp0_valid = rsp_avail[0];
    assign rsp1_valid = rsp_avail[1];
    assign rsp0_sum   = rsp_avail[0] ? f_sum[0][rd_ptr[0]]   : '0;
    assign rsp0_carry = rsp_avail[0] ? f_carry[0][rd_ptr[0]] : '0;
    assign rsp0_tag   = rsp_avail[0] ? f_tag[0][rd_ptr[0]]   : '0;
    assign rsp1_sum   = rsp_avail[1] ? f_sum[1][rd_ptr[1]]   : '0;
    assign rsp1_carry = rsp_avail[1] ? f_carry[1][rd_ptr[1]] : '0;
    assign rsp1_tag   = rsp_avail[1] ? f_tag[1][rd_ptr[1]]   : '0;

`ifdef SIGMUL_SCHED_STATS_EN
    logic stall_any;
    assign stall_any = (req0_valid && credit[0] == '0) || (req1_valid && credit[1] == '0);

    // Saturating accept and stall counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_issue0 <= '0;
            stat_issue1 <= '0;
            stat_stall  <= '0;
        end else begin
            if (grant[0] && stat_issue0 != 16'hFFFF) stat_issue0 <= stat_issue0 + 16'd1;
            if (grant[1] && stat_issue1 != 16'hFFFF) stat_issue1 <= stat_issue1 + 16'd1;
            if (stall_any && stat_stall != 16'hFFFF) stat_stall  <= stat_stall + 16'd1;
        end
    end
`endif

endmodule
